// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order prediction FIFO resolving branches at execute and driving BTB update/flush
// Optional saturating perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_push,
  input  logic [XLEN-1:0] dec_pc,
  input  logic            dec_pred_taken,
  input  logic [XLEN-1:0] dec_pred_tgt,
  output logic            pred_full,
  input  logic            ex_resolve,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            update,
  output logic [XLEN-1:0] update_pc,
  output logic [XLEN-1:0] update_target,
  output logic            mispredicted,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            err,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispreds
);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = FLUSH_CYC > 1 ? $clog2(FLUSH_CYC) : 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t          state;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [XLEN-1:0] q_tgt [DEPTH];
  logic [DEPTH-1:0] q_taken;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic [FW-1:0]   fcnt;
  logic            run, pop, push, mp, pc_bad, ovf, unf;
  logic [XLEN-1:0] act_pc;
  always_comb begin
    run       = state == RUN;
    pred_full = count == (PW+1)'(DEPTH);
    pop       = run && ex_resolve && count != '0;
    unf       = run && ex_resolve && count == '0;
    pc_bad    = ex_pc != q_pc[rd_ptr];
    mp        = pop && (ex_taken != q_taken[rd_ptr] || (ex_taken && ex_target != q_tgt[rd_ptr]) || pc_bad);
    push      = run && dec_push && (!pred_full || pop) && !mp;
    ovf       = run && dec_push && pred_full && !pop;
    act_pc    = ex_taken ? ex_target : ex_pc + XLEN'(4);
  end
  always_ff @(posedge clk)
    if (push) begin
      q_pc[wr_ptr]    <= dec_pc;
      q_tgt[wr_ptr]   <= dec_pred_tgt;
      q_taken[wr_ptr] <= dec_pred_taken;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fcnt          <= '0;
      update        <= 1'b0;
      update_pc     <= '0;
      update_target <= '0;
      mispredicted  <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      err           <= 1'b0;
    end else begin
      update       <= pop && (ex_taken || mp);
      mispredicted <= mp;
      if (pop) begin
        update_pc     <= ex_pc;
        update_target <= act_pc;
      end
      if (unf || ovf || (pop && pc_bad)) err <= 1'b1;
      // a mispredict discards every younger entry, including one pushed this cycle
      if (mp) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        fcnt        <= '0;
        flush       <= 1'b1;
        redirect_pc <= act_pc;
        state       <= FLUSH;
      end else if (run) begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        count  <= count + (PW+1)'(push) - (PW+1)'(pop);
      end else if (fcnt == FW'(FLUSH_CYC-1)) begin
        flush <= 1'b0;
        state <= RUN;
      end else fcnt <= fcnt + 1'b1;
    end
`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_branches <= '0;
      perf_mispreds <= '0;
    end else begin
      if (pop && perf_branches != '1) perf_branches <= perf_branches + 1'b1;
      if (mp && perf_mispreds != '1) perf_mispreds <= perf_mispreds + 1'b1;
    end
`else
  assign perf_branches = '0;
  assign perf_mispreds = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table, corner sequences and randomized run against a queue model
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int FC    = 2;
  logic        clk = 1'b0, rst = 1'b1;
  logic        dec_push = 0, dec_pred_taken = 0, ex_resolve = 0, ex_taken = 0;
  logic [31:0] dec_pc = 0, dec_pred_tgt = 0, ex_pc = 0, ex_target = 0;
  logic        pred_full, update, mispredicted, flush, err;
  logic [31:0] update_pc, update_target, redirect_pc, perf_branches, perf_mispreds;
  always #5 clk = ~clk;
  branch_resolve_unit #(.XLEN(32), .DEPTH(DEPTH), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst), .dec_push(dec_push), .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
    .dec_pred_tgt(dec_pred_tgt), .pred_full(pred_full), .ex_resolve(ex_resolve), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .update(update), .update_pc(update_pc),
    .update_target(update_target), .mispredicted(mispredicted), .flush(flush),
    .redirect_pc(redirect_pc), .err(err), .perf_branches(perf_branches), .perf_mispreds(perf_mispreds));

  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  typedef struct {logic [31:0] pc, tgt; logic tk;} ent_t;
  ent_t        q[$];
  int          fl_left;
  logic        m_err, m_upd, m_mp;
  logic [31:0] m_upc, m_utgt, m_redir, m_br, m_mpc;

  task automatic model_reset();
    q.delete();
    fl_left = 0; m_err = 0; m_upd = 0; m_mp = 0;
    m_upc = 0; m_utgt = 0; m_redir = 0; m_br = 0; m_mpc = 0;
  endtask

  task automatic step(input logic p, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic r, input logic [31:0] epc, input logic etk, input logic [31:0] etgt);
    ent_t h;
    logic mp, bad;
    dec_push = p; dec_pc = pc; dec_pred_taken = tk; dec_pred_tgt = tgt;
    ex_resolve = r; ex_pc = epc; ex_taken = etk; ex_target = etgt;
    mp = 0; m_upd = 0; m_mp = 0;
    if (fl_left > 0) fl_left--;
    else begin
      if (r) begin
        if (q.size() == 0) m_err = 1;
        else begin
          h = q.pop_front();
          bad = epc != h.pc;
          mp = (etk != h.tk) || (etk && etgt != h.tgt) || bad;
          if (bad) m_err = 1;
          m_upd = etk | mp; m_mp = mp;
          m_upc = epc; m_utgt = etk ? etgt : epc + 32'd4;
          if (m_br != '1) m_br++;
        end
      end
      if (p && !mp) begin
        if (q.size() < DEPTH) q.push_back('{pc: pc, tgt: tgt, tk: tk});
        else m_err = 1;
      end
      if (mp) begin
        q.delete();
        m_redir = etk ? etgt : epc + 32'd4;
        fl_left = FC;
        if (m_mpc != '1) m_mpc++;
      end
    end
    @(posedge clk); #1;
    chk("update", {31'b0, update}, {31'b0, m_upd});
    chk("mispredicted", {31'b0, mispredicted}, {31'b0, m_mp});
    chk("flush", {31'b0, flush}, {31'b0, fl_left > 0});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("pred_full", {31'b0, pred_full}, {31'b0, q.size() == DEPTH});
    if (m_upd) begin
      chk("update_pc", update_pc, m_upc);
      chk("update_target", update_target, m_utgt);
    end
    if (fl_left > 0) chk("redirect_pc", redirect_pc, m_redir);
`ifdef BRU_PERF_CNT_EN
    chk("perf_branches", perf_branches, m_br);
    chk("perf_mispreds", perf_mispreds, m_mpc);
`else
    chk("perf_branches", perf_branches, 32'd0);
    chk("perf_mispreds", perf_mispreds, 32'd0);
`endif
  endtask

  task automatic do_reset();
    dec_push = 0; ex_resolve = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {update, mispredicted, flush, err, pred_full}, 5'd0);
    chk("rst_update_pc", update_pc, 0);
    chk("rst_update_target", update_target, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_perf", perf_branches | perf_mispreds, 0);
    rst = 0;
  endtask

  typedef struct {
    logic p; logic [31:0] pc; logic tk; logic [31:0] tgt;
    logic r; logic [31:0] epc; logic etk; logic [31:0] etgt;
    logic upd, mp, fl, er, full; logic [31:0] utgt, redir;
  } vec_t;
  vec_t v[16];

  function automatic vec_t mk(input int p, input logic [31:0] pc, input int tk, input logic [31:0] tgt,
                              input int r, input logic [31:0] epc, input int etk, input logic [31:0] etgt,
                              input int upd, input int mp, input int fl, input int er, input int full,
                              input logic [31:0] utgt, input logic [31:0] redir);
    vec_t x;
    x.p = p != 0; x.pc = pc; x.tk = tk != 0; x.tgt = tgt;
    x.r = r != 0; x.epc = epc; x.etk = etk != 0; x.etgt = etgt;
    x.upd = upd != 0; x.mp = mp != 0; x.fl = fl != 0; x.er = er != 0; x.full = full != 0;
    x.utgt = utgt; x.redir = redir;
    return x;
  endfunction

  initial begin
    v[0]  = mk(1, 32'h000A0000, 1, 32'h000A0020, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[1]  = mk(0, 0, 0, 0,                       1, 32'h000A0000, 1, 32'h000A0020, 1, 0, 0, 0, 0, 32'h000A0020, 0);
    v[2]  = mk(1, 32'h000B0000, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[3]  = mk(1, 32'h000B0010, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[4]  = mk(0, 0, 0, 0,                       1, 32'h000B0000, 1, 32'h000B0020, 1, 1, 1, 0, 0, 32'h000B0020, 32'h000B0020);
    v[5]  = mk(1, 32'h000B0030, 1, 32'h000B0040, 1, 32'h000B0010, 0, 0,            0, 0, 1, 0, 0, 0, 32'h000B0020);
    v[6]  = mk(0, 0, 0, 0,                       0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[7]  = mk(1, 32'h000C0000, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[8]  = mk(0, 0, 0, 0,                       1, 32'h000C0000, 0, 0,            0, 0, 0, 0, 0, 0, 0);
    v[9]  = mk(1, 32'h000D0000, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[10] = mk(1, 32'h000D0010, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[11] = mk(1, 32'h000D0020, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);
    v[12] = mk(1, 32'h000D0030, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 0, 1, 0, 0);
    v[13] = mk(1, 32'h000D0040, 0, 0,            0, 0, 0, 0,                       0, 0, 0, 1, 1, 0, 0);
    v[14] = mk(1, 32'h000D0050, 0, 0,            1, 32'h000D0000, 0, 0,            0, 0, 0, 1, 1, 0, 0);
    v[15] = mk(0, 0, 0, 0,                       1, 32'h000D0010, 0, 0,            0, 0, 0, 1, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(v[i].p, v[i].pc, v[i].tk, v[i].tgt, v[i].r, v[i].epc, v[i].etk, v[i].etgt);
      chk($sformatf("vec%0d_update", i), {31'b0, update}, {31'b0, v[i].upd});
      chk($sformatf("vec%0d_mispredicted", i), {31'b0, mispredicted}, {31'b0, v[i].mp});
      chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, v[i].fl});
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, v[i].er});
      chk($sformatf("vec%0d_full", i), {31'b0, pred_full}, {31'b0, v[i].full});
      if (v[i].upd) chk($sformatf("vec%0d_utgt", i), update_target, v[i].utgt);
      if (v[i].fl) chk($sformatf("vec%0d_redirect", i), redirect_pc, v[i].redir);
    end

    do_reset();
    step(0, 0, 0, 0, 1, 32'h00001000, 1, 32'h00002000);
    chk("empty_resolve_update", {31'b0, update}, 32'd0);
    chk("empty_resolve_err", {31'b0, err}, 32'd1);

    do_reset();
    step(1, 32'hFFFFFFFC, 1, 32'h00000100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
    chk("wrap_redirect", redirect_pc, 32'h00000000);
    chk("wrap_utgt", update_target, 32'h00000000);
    #2 rst = 1;
    #1;
    chk("async_rst_flush", {31'b0, flush}, 32'd0);
    chk("async_rst_full", {31'b0, pred_full}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic p, tk, r, etk;
      logic [31:0] pc, tgt, epc, etgt;
      if (c % 400 == 399) do_reset();
      p   = ($urandom % 2) == 0;
      pc  = ($urandom % 16 == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      tk  = $urandom % 2;
      tgt = $urandom & 32'hFFFFFFFC;
      r   = ($urandom % 3) != 0;
      epc = $urandom & 32'hFFFFFFFC;
      etk = $urandom % 2;
      etgt = $urandom & 32'hFFFFFFFC;
      if (q.size() != 0 && $urandom % 16 != 0) begin
        epc = q[0].pc;
        etk = ($urandom % 4 == 0) ? ~q[0].tk : q[0].tk;
        if (etk && q[0].tk && $urandom % 4 != 0) etgt = q[0].tgt;
      end else if (q.size() == 0 && $urandom % 8 != 0) r = 0;
      step(p, pc, tk, tgt, r, epc, etk, etgt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
